// File: rtl/arm_isa_pkg.sv
// arm_isa_pkg
//   Field constants and per-class encode helpers for the ARM subset that the
//   single-cycle core decodes (ADD, SUB, AND, ORR, CMP, LDR/STR imm, B/BL).
//   Shared by the decoder and by arm_instr_encoder so both ends agree on
//   every bit position.
package arm_isa_pkg;

  typedef enum logic [1:0] {
    CLS_DP  = 2'b00,
    CLS_MEM = 2'b01,
    CLS_BR  = 2'b10,
    CLS_ILL = 2'b11
  } instr_class_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [2:0] OP_BR  = 3'b101;

  function automatic logic dp_cmd_legal(input logic [3:0] cmd);
    return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
           (cmd == CMD_CMP) || (cmd == CMD_ORR);
  endfunction

  // CMP only exists as a flag-setting compare with no destination,
  // so S and Rd are forced regardless of what the caller supplied.
  function automatic logic [31:0] enc_dp(input logic [3:0]  cond,
                                         input logic        i,
                                         input logic [3:0]  cmd,
                                         input logic        s,
                                         input logic [3:0]  rn,
                                         input logic [3:0]  rd,
                                         input logic [11:0] src2);
    logic       s_eff;
    logic [3:0] rd_eff;
    s_eff  = (cmd == CMD_CMP) ? 1'b1 : s;
    rd_eff = (cmd == CMD_CMP) ? 4'h0 : rd;
    return {cond, OP_DP, i, cmd, s_eff, rn, rd_eff, src2};
  endfunction

  // Immediate-offset, pre-indexed, add, word, no writeback: I=0 P=1 U=1 B=0 W=0.
  function automatic logic [31:0] enc_mem(input logic [3:0]  cond,
                                          input logic        l,
                                          input logic [3:0]  rn,
                                          input logic [3:0]  rd,
                                          input logic [11:0] imm12);
    return {cond, OP_MEM, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, l, rn, rd, imm12};
  endfunction

  function automatic logic [31:0] enc_br(input logic [3:0]  cond,
                                         input logic        link,
                                         input logic [23:0] imm24);
    return {cond, OP_BR, link, imm24};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO, synchronous active-high reset.
//   Ports:
//     i_clk, i_rst        clock / reset (reset empties the FIFO)
//     i_push, i_din       write one entry (ignored when full)
//     i_pop               remove head entry (ignored when empty)
//     o_dout              head entry (undefined when empty)
//     o_full, o_empty     occupancy flags
//   Simultaneous push and pop leaves occupancy unchanged.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/arm_instr_encoder.sv
// arm_instr_encoder
//   Packs field-level instruction descriptors into 32-bit ARM words and
//   streams them into instruction memory at consecutive word addresses.
//   Ports:
//     CLK, Reset                 clock, synchronous active-high reset
//     req_valid/req_ready        descriptor handshake (ready = FIFO not full)
//     req_class..req_imm         descriptor fields
//     base_load, base_addr       relocate the write pointer (only when idle)
//     imem_we/addr/wd/ready      buffered memory write port
//     words_written              completed writes, wrapping 16-bit count
//     err_illegal, err_busy      sticky error flags, cleared by Reset only
module arm_instr_encoder
  import arm_isa_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_class,
  input  logic [3:0]  req_cond,
  input  logic [3:0]  req_cmd,
  input  logic        req_i,
  input  logic        req_s,
  input  logic        req_link,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rd,
  input  logic [23:0] req_imm,
  input  logic        base_load,
  input  logic [31:0] base_addr,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  input  logic        imem_ready,
  output logic [15:0] words_written,
  output logic        err_illegal,
  output logic        err_busy
);

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;
  logic        w_base_ok;
  logic        w_unused_addr_lsb;

  logic [31:0] r_addr;
  logic [15:0] r_words;
  logic        r_err_illegal;
  logic        r_err_busy;

  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (req_class)
      CLS_DP: begin
        w_word  = enc_dp(req_cond, req_i, req_cmd, req_s, req_rn, req_rd, req_imm[11:0]);
        w_legal = dp_cmd_legal(req_cmd);
      end
      CLS_MEM: begin
        w_word  = enc_mem(req_cond, req_s, req_rn, req_rd, req_imm[11:0]);
        w_legal = 1'b1;
      end
      CLS_BR: begin
        w_word  = enc_br(req_cond, req_link, req_imm);
        w_legal = 1'b1;
      end
      default: begin
        w_word  = '0;
        w_legal = 1'b0;
      end
    endcase
    if (req_cond == COND_NV) w_legal = 1'b0;
  end

  assign req_ready = !w_full;
  assign w_accept  = req_valid && req_ready;
  assign w_push    = w_accept && w_legal;

  // Strobe is held off during Reset so memory never sees a write that the
  // address/count registers are about to forget.
  assign imem_we   = !w_empty && !Reset;
  assign imem_wd   = w_empty ? 32'h0 : w_head;
  assign imem_addr = r_addr;
  assign w_pop     = imem_we && imem_ready;

  // Relocation is only safe when nothing is queued or arriving, otherwise
  // queued words would land at the wrong address.
  assign w_base_ok         = w_empty && !w_push;
  assign w_unused_addr_lsb = ^base_addr[1:0];

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_din   (w_word),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_addr        <= RESET_ADDR;
      r_words       <= '0;
      r_err_illegal <= 1'b0;
      r_err_busy    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr  <= r_addr + 32'd4;
        r_words <= r_words + 16'd1;
      end else if (base_load && w_base_ok) begin
        r_addr <= {base_addr[31:2], 2'b00};
      end
      if (w_accept && !w_legal) r_err_illegal <= 1'b1;
      if (base_load && !w_base_ok) r_err_busy <= 1'b1;
    end
  end

  assign words_written = r_words;
  assign err_illegal   = r_err_illegal;
  assign err_busy      = r_err_busy;

endmodule

// File: tb/tb_arm_instr_encoder.sv
module tb_arm_instr_encoder;

  typedef struct {
    logic [1:0]  cls;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        i;
    logic        s;
    logic        link;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [23:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_class = '0;
  logic [3:0]  req_cond = '0;
  logic [3:0]  req_cmd = '0;
  logic        req_i = 1'b0;
  logic        req_s = 1'b0;
  logic        req_link = 1'b0;
  logic [3:0]  req_rn = '0;
  logic [3:0]  req_rd = '0;
  logic [23:0] req_imm = '0;
  logic        base_load = 1'b0;
  logic [31:0] base_addr = '0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        imem_ready = 1'b0;
  logic [15:0] words_written;
  logic        err_illegal;
  logic        err_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  vec_t tbl[11];

  always #5 CLK = ~CLK;

  arm_instr_encoder #(.DEPTH(4), .RESET_ADDR(32'h0)) dut (
    .CLK(CLK), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_cond(req_cond), .req_cmd(req_cmd),
    .req_i(req_i), .req_s(req_s), .req_link(req_link),
    .req_rn(req_rn), .req_rd(req_rd), .req_imm(req_imm),
    .base_load(base_load), .base_addr(base_addr),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .imem_ready(imem_ready), .words_written(words_written),
    .err_illegal(err_illegal), .err_busy(err_busy)
  );

  // Inputs only change at posedge+1, so at the negedge the handshake
  // values show exactly what the next posedge will commit.
  always @(negedge CLK) begin
    if (Reset === 1'b0 && imem_we === 1'b1 && imem_ready === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wd);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] cls, input logic [3:0] cond,
                              input logic [3:0] cmd, input logic i, input logic s,
                              input logic link, input logic [3:0] rn,
                              input logic [3:0] rd, input logic [23:0] imm,
                              input logic [31:0] exp);
    vec_t v;
    v.cls = cls; v.cond = cond; v.cmd = cmd; v.i = i; v.s = s; v.link = link;
    v.rn = rn; v.rd = rd; v.imm = imm; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_class = v.cls; req_cond = v.cond; req_cmd = v.cmd; req_i = v.i;
    req_s = v.s; req_link = v.link; req_rn = v.rn; req_rd = v.rd; req_imm = v.imm;
    req_valid = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    Reset = 1'b1; req_valid = 1'b0; base_load = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    Reset = 1'b0;
    log_addr.delete(); log_data.delete();
  endtask

  task automatic send(input vec_t v);
    int n;
    n = 0;
    @(posedge CLK); #1;
    drive(v);
    @(negedge CLK);
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("send_ready", {31'b0, req_ready}, 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge CLK);
    while (imem_we && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_done", {31'b0, imem_we}, 32'd0);
  endtask

  task automatic chk_log(input string name, input int idx,
                         input logic [31:0] ea, input logic [31:0] ed);
    if (idx < log_data.size()) begin
      chk({name, "_addr"}, log_addr[idx], ea);
      chk({name, "_data"}, log_data[idx], ed);
    end else begin
      chk({name, "_present"}, 32'(log_data.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    vec_t v;
    //            cls    cond  cmd   i     s     link  rn    rd    imm          expected
    tbl[0]  = mk(2'd0, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 4'h2, 4'h1, 24'hFFF005, 32'hE2821005);
    tbl[1]  = mk(2'd1, 4'hE, 4'hF, 1'b1, 1'b0, 1'b1, 4'h4, 4'h3, 24'h000008, 32'hE5843008);
    tbl[2]  = mk(2'd1, 4'hE, 4'h0, 1'b0, 1'b1, 1'b0, 4'h4, 4'h3, 24'h000008, 32'hE5943008);
    tbl[3]  = mk(2'd0, 4'hE, 4'hA, 1'b1, 1'b0, 1'b0, 4'h1, 4'h7, 24'h000000, 32'hE3510000);
    tbl[4]  = mk(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hFFFFFE, 32'hEAFFFFFE);
    tbl[5]  = mk(2'd2, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 24'hFFFFFE, 32'hEBFFFFFE);
    tbl[6]  = mk(2'd0, 4'h0, 4'hC, 1'b0, 1'b1, 1'b0, 4'h5, 4'h6, 24'h0000A3, 32'h019560A3);
    tbl[7]  = mk(2'd0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hE, 24'h555FFF, 32'h120FEFFF);
    tbl[8]  = mk(2'd0, 4'hA, 4'h2, 1'b0, 1'b1, 1'b0, 4'h3, 4'h4, 24'h000104, 32'hA0534104);
    tbl[9]  = mk(2'd1, 4'h3, 4'h0, 1'b0, 1'b1, 1'b0, 4'hD, 4'h0, 24'h123ABC, 32'h359D0ABC);
    tbl[10] = mk(2'd2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h000001, 32'h0A000001);

    // Reset values
    do_reset();
    @(negedge CLK);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_we", {31'b0, imem_we}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wd", imem_wd, 32'h0);
    chk("rst_words", {16'b0, words_written}, 32'd0);
    chk("rst_err_illegal", {31'b0, err_illegal}, 32'd0);
    chk("rst_err_busy", {31'b0, err_busy}, 32'd0);

    // First accept to imem_we latency
    imem_ready = 1'b1;
    @(posedge CLK); #1;
    drive(tbl[0]);
    @(negedge CLK);
    chk("lat_we_before", {31'b0, imem_we}, 32'd0);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    chk("lat_we", {31'b0, imem_we}, 32'd1);
    chk("lat_addr", imem_addr, 32'h0);
    chk("lat_wd", imem_wd, 32'hE2821005);
    @(negedge CLK);
    chk("lat_we_after", {31'b0, imem_we}, 32'd0);
    chk("lat_words", {16'b0, words_written}, 32'd1);
    chk("lat_addr_after", imem_addr, 32'h4);

    // Table of encodings, streamed back to back
    do_reset();
    imem_ready = 1'b1;
    for (int k = 0; k < 11; k++) send(tbl[k]);
    wait_drain();
    chk("tbl_count", 32'(log_data.size()), 32'd11);
    for (int k = 0; k < 11; k++) chk_log($sformatf("tbl%0d", k), k, 32'(4 * k), tbl[k].exp);
    chk("tbl_words", {16'b0, words_written}, 32'd11);

    // Backpressure: fill, hold, then drain in order
    do_reset();
    imem_ready = 1'b0;
    v = tbl[4];
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      v.imm = 24'(k);
      drive(v);
      @(negedge CLK);
      chk($sformatf("full_ready%0d", k), {31'b0, req_ready}, 32'd1);
    end
    @(posedge CLK); #1;
    v.imm = 24'd4;
    drive(v);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("full_ready_low", {31'b0, req_ready}, 32'd0);
      chk("full_hold_we", {31'b0, imem_we}, 32'd1);
      chk("full_hold_wd", imem_wd, 32'hEA000000);
      chk("full_hold_addr", imem_addr, 32'h0);
    end
    @(posedge CLK); #1;
    imem_ready = 1'b1;
    @(negedge CLK);
    chk("full_ready_popcyc", {31'b0, req_ready}, 32'd0);
    @(negedge CLK);
    chk("full_ready_after_pop", {31'b0, req_ready}, 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    wait_drain();
    chk("full_count", 32'(log_data.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      chk_log($sformatf("full%0d", k), k, 32'(4 * k), 32'hEA000000 | 32'(k));

    // Illegal descriptors are consumed but never written
    do_reset();
    imem_ready = 1'b1;
    v = tbl[0]; v.cls = 2'd3;                 send(v);
    v = tbl[0]; v.cmd = 4'h1;                 send(v);
    v = tbl[1]; v.cond = 4'hF;                send(v);
    repeat (3) @(negedge CLK);
    chk("ill_written", 32'(log_data.size()), 32'd0);
    chk("ill_flag", {31'b0, err_illegal}, 32'd1);
    chk("ill_words", {16'b0, words_written}, 32'd0);
    chk("ill_busy", {31'b0, err_busy}, 32'd0);

    // base_load while busy, then while idle, then address wrap
    do_reset();
    imem_ready = 1'b0;
    send(tbl[0]);
    base_load = 1'b1; base_addr = 32'h0000_0103;
    @(posedge CLK); #1;
    base_load = 1'b0;
    @(negedge CLK);
    chk("busy_flag", {31'b0, err_busy}, 32'd1);
    chk("busy_addr", imem_addr, 32'h0);
    @(posedge CLK); #1;
    imem_ready = 1'b1;
    wait_drain();
    chk_log("busy_w0", 0, 32'h0, 32'hE2821005);
    @(posedge CLK); #1;
    base_load = 1'b1; base_addr = 32'h0000_0103;
    @(posedge CLK); #1;
    base_load = 1'b0;
    @(negedge CLK);
    chk("base_addr", imem_addr, 32'h100);
    send(tbl[3]);
    wait_drain();
    chk_log("base_w", 1, 32'h100, 32'hE3510000);
    @(posedge CLK); #1;
    base_load = 1'b1; base_addr = 32'hFFFF_FFFF;
    @(posedge CLK); #1;
    base_load = 1'b0;
    send(tbl[4]);
    send(tbl[5]);
    wait_drain();
    chk_log("wrap0", 2, 32'hFFFF_FFFC, 32'hEAFFFFFE);
    chk_log("wrap1", 3, 32'h0, 32'hEBFFFFFE);
    chk("busy_sticky", {31'b0, err_busy}, 32'd1);

    // base_load coinciding with a push into an empty FIFO is ignored
    do_reset();
    imem_ready = 1'b1;
    @(posedge CLK); #1;
    drive(tbl[0]);
    base_load = 1'b1; base_addr = 32'h0000_0200;
    @(posedge CLK); #1;
    req_valid = 1'b0; base_load = 1'b0;
    @(negedge CLK);
    chk("coll_busy", {31'b0, err_busy}, 32'd1);
    chk("coll_addr", imem_addr, 32'h0);
    chk("coll_we", {31'b0, imem_we}, 32'd1);
    wait_drain();

    // Reset in the middle of a drain
    do_reset();
    imem_ready = 1'b0;
    send(tbl[4]);
    send(tbl[5]);
    send(tbl[6]);
    @(posedge CLK); #1;
    imem_ready = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(negedge CLK);
    chk("mid_rst_we_during", {31'b0, imem_we}, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(negedge CLK);
    chk("mid_rst_we", {31'b0, imem_we}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_words", {16'b0, words_written}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/arm_instr_encoder.md
Name: arm_instr_encoder

Overview:
Inverse of the processor's instruction decoder. Accepts field-level instruction descriptors over a valid/ready handshake, packs them into 32-bit ARM words, and writes them sequentially into instruction memory through a buffered write port. Used by the program loader and test infrastructure to build programs the single-cycle core can execute. Encodes exactly the subset the core decodes: ADD, SUB, AND, ORR, CMP, LDR/STR with immediate offset, and B/BL.

Parameters:
DEPTH, 4, entries in the encoded-word FIFO (power of two, ≥2)
RESET_ADDR, 32'h0000_0000, first imem write address after reset

Ports:
CLK  in  1  clock
Reset  in  1  synchronous, active-high reset
req_valid  in  1  descriptor valid
req_ready  out  1  descriptor accepted when valid&ready
req_class  in  2  00 DP, 01 MEM, 10 BRANCH, 11 illegal
req_cond  in  4  condition field
req_cmd  in  4  DP command
req_i  in  1  DP immediate select
req_s  in  1  DP S bit / MEM L bit
req_link  in  1  BL when class=BRANCH
req_rn  in  4  Rn
req_rd  in  4  Rd
req_imm  in  24  imm24 (branch); [11:0] Src2 (DP) / imm12 (MEM)
base_load  in  1  load new write address
base_addr  in  32  address for base_load, [1:0] ignored
imem_we  out  1  write strobe
imem_addr  out  32  write address
imem_wd  out  32  write data
imem_ready  in  1  memory accepts write when imem_we&imem_ready
words_written  out  16  count of completed writes, wraps
err_illegal  out  1  sticky: illegal descriptor dropped
err_busy  out  1  sticky: base_load ignored

Behaviour:
- The clock is CLK; reset is synchronous, active-high, on Reset. One clock domain.
- Reset values: FIFO empty, imem_we=0, imem_addr=RESET_ADDR, imem_wd=0, words_written=0, err_illegal=0, err_busy=0, req_ready=1 after reset. Reset mid-transfer discards all FIFO contents. No partial write completes in the reset cycle.
- req_ready = FIFO not full. It is registered-state derived and has no combinational dependence on req_valid.
- Encoding is combinational from the request fields. The word is pushed into the FIFO on the accept edge.
  - DP: cond|00|I|cmd|S|Rn|Rd|imm[11:0].
  - CMP (1010): S forced to 1 and Rd forced to 0.
  - MEM: cond|01|0|1|1|0|0|L|Rn|Rd|imm[11:0], i.e. P=1, U=1, B=0, W=0, immediate offset.
  - BRANCH: cond|101|link|imm[23:0].
- Illegal descriptors are accepted (ready honoured) but not pushed, and they set err_illegal. A descriptor is illegal if any of the following holds:
  - class=11
  - cond=1111
  - DP cmd not in {0000, 0010, 0100, 1010, 1100}
- Write side: imem_we = FIFO not empty. imem_wd = FIFO head and imem_addr = current address, both stable while imem_we&!imem_ready.
- On imem_we&imem_ready: pop, imem_addr += 4 (wraps mod 2^32), words_written += 1 (wraps at 16'hFFFF→0).
- Push and pop in the same cycle: occupancy unchanged. This is allowed when full, but req_ready is already low that cycle, so no push occurs. Latency from accept to imem_we is 1 cycle when the FIFO was empty.
- base_load is honoured only when the FIFO is empty and no push occurs that cycle: imem_addr ← {base_addr[31:2], 2'b00} next cycle. Otherwise it is ignored and err_busy is set.
- Error flags clear only on Reset.

Decomposition:
- Shared package arm_isa_pkg holds:
  - class codes
  - DP command constants (AND, SUB, ADD, CMP, ORR)
  - COND_AL=4'hE and COND_NV=4'hF
  - op field constants
  - an encode function per class
- The decoder uses the same constants.
- Sub-module sync_fifo (parameterised width/depth, full/empty, simultaneous push/pop) holds encoded words. Address and count logic stay in the top.

Test Plan:
- After reset: DP ADD, cond E, I=1, Rn=2, Rd=1, imm=005 -> imem_wd=E2821005 at addr 0, one cycle after accept; words_written=1.
- STR R3,[R4,#8] then LDR same fields with L=1 -> E5843008 at 0, E5943008 at 4.
- CMP R1,#0 with req_rd=7, S=0 -> E3510000. B imm=FFFFFE -> EAFFFFFE. BL -> EBFFFFFE.
- DEPTH=4, imem_ready=0, 5 valid requests -> 4 accepted, req_ready=0 and held. Raise imem_ready -> writes drain in order at addrs 0,4,8,C; 5th accepted the cycle after first pop.
- class=11, then DP cmd=0001, then cond=F -> all accepted, none written, err_illegal=1, words_written unchanged.
- base_load=1, base_addr=0x103 with FIFO non-empty -> err_busy=1, address sequence unchanged. Repeat when empty -> next write at 0x100. Assert Reset mid-drain -> imem_we=0, imem_addr=0 next cycle.
